// File: rtl/jtag_host.sv
// JTAG initiator: runs whole TAP operations (reset, IR scan, DR scan, idle clocks)
// from a command interface, generating TCK at tclk/2 and sampling TDO on TCK falling.
module jtag_host #(
    parameter int IR_LEN = 6,
    parameter int DR_MAX = 41
) (
    input  logic              tclk,
    input  logic              trst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [6:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);
    localparam int IW = $clog2(DR_MAX + 1);
    localparam logic [1:0] OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_IDLE = 2'd3;

    typedef enum logic [2:0] {INIT, IDLE, HEAD, SHIFT, TAIL, CLOCK, DONE} state_t;

    state_t            state, state_d;
    logic [1:0]        op;
    logic              from_init;
    logic [5:0]        hdr;
    logic [6:0]        cnt;
    logic [IW-1:0]     idx, slen, dr_len;
    logic [DR_MAX-1:0] dat, cap;
    logic              accept, fin, seg_last, shift_last;

    assign dr_len     = (cmd_len > 7'(DR_MAX)) ? IW'(DR_MAX) : cmd_len[IW-1:0];
    assign seg_last   = (cnt == 7'd1);
    assign shift_last = (idx == slen - IW'(1));

    always_ff @(posedge tclk or negedge trst)
        if (!trst) state <= INIT;
        else       state <= state_d;

    always_comb begin
        state_d = state;
        accept  = cmd_valid && cmd_ready;
        fin     = 1'b0;
        case (state)
            INIT: state_d = HEAD;
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept)
                    case (cmd_op)
                        OP_DR:   state_d = (dr_len == '0) ? DONE : HEAD;
                        OP_IDLE: state_d = (cmd_len == '0) ? DONE : CLOCK;
                        default: state_d = HEAD;
                    endcase
            end
            HEAD:        if (tck && seg_last) state_d = (op == OP_RST) ? DONE : SHIFT;
            SHIFT:       if (tck && shift_last) state_d = TAIL;
            TAIL, CLOCK: if (tck && seg_last) state_d = DONE;
            default:     state_d = INIT;
        endcase
        // end of the last phase B of a clocked operation
        fin = tck && (state_d == DONE) && (state == HEAD || state == TAIL || state == CLOCK);
    end

    always_ff @(posedge tclk or negedge trst) begin
        if (!trst) begin
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            op        <= OP_RST;
            from_init <= 1'b1;
            hdr       <= '0;
            cnt       <= '0;
            idx       <= '0;
            slen      <= '0;
            dat       <= '0;
            cap       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                INIT: begin
                    op        <= OP_RST;
                    from_init <= 1'b1;
                    hdr       <= 6'b011111;
                    cnt       <= 7'd6;
                    tms       <= 1'b1;
                    cap       <= '0;
                end
                IDLE, DONE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        from_init <= 1'b0;
                        op        <= cmd_op;
                        dat       <= cmd_data;
                        cap       <= '0;
                        idx       <= '0;
                        slen      <= (cmd_op == OP_IR) ? IW'(IR_LEN) : dr_len;
                        tms       <= 1'b1;
                        // header patterns are stored first-bit-in-LSB
                        case (cmd_op)
                            OP_RST:  begin hdr <= 6'b011111; cnt <= 7'd6; end
                            OP_IR:   begin hdr <= 6'b000011; cnt <= 7'd4; end
                            OP_DR:   begin hdr <= 6'b000001; cnt <= 7'd3; end
                            default: begin tms <= 1'b0;      cnt <= cmd_len; end
                        endcase
                        if (state_d == DONE) begin
                            tms       <= 1'b0;
                            cmd_ready <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end
                HEAD: begin
                    tck <= ~tck;
                    if (tck) begin
                        if (!seg_last) begin
                            cnt <= cnt - 7'd1;
                            hdr <= hdr >> 1;
                            tms <= hdr[1];
                        end else if (op != OP_RST) begin
                            tms <= (slen == IW'(1));
                            tdi <= dat[0];
                        end
                    end
                end
                SHIFT: begin
                    tck <= ~tck;
                    if (tck) begin
                        cap[idx] <= tdo;
                        if (shift_last) begin
                            tms <= 1'b1;
                            tdi <= 1'b0;
                            cnt <= 7'd2;
                        end else begin
                            idx <= idx + IW'(1);
                            tms <= (idx + IW'(2) == slen);
                            tdi <= dat[1];
                            dat <= dat >> 1;
                        end
                    end
                end
                TAIL, CLOCK: begin
                    tck <= ~tck;
                    if (tck && !seg_last) begin
                        cnt <= cnt - 7'd1;
                        tms <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (fin) begin
                tms       <= 1'b0;
                tdi       <= 1'b0;
                rsp_valid <= !from_init;
                cmd_ready <= !from_init;
                rsp_data  <= cap;
            end
        end
    end
endmodule
